// File: rtl/param_step_counter.sv
// param_step_counter: WIDTH-bit up/down step counter with EVEN/ODD/UNIT/PARAM modes,
// synchronous aligned load, and wrap or saturate handling at the range ends.
// Latency: one clk from the en/load sample to q. tc and at_limit are registered and track that q.
// No backpressure: the counter advances on every enabled edge and holds when en is low.
module param_step_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      STEP     = 3,
  parameter logic [WIDTH-1:0] START    = '0,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_limit
);

  typedef enum logic [1:0] {
    MODE_EVEN  = 2'b00,
    MODE_ODD   = 2'b01,
    MODE_UNIT  = 2'b10,
    MODE_PARAM = 2'b11
  } mode_e;

  // One extra bit above the count width catches the carry or borrow of a step.
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  // Force bit0 to match the parity of EVEN/ODD modes; UNIT and PARAM pass through.
  function automatic logic [WIDTH-1:0] align_f(input logic [WIDTH-1:0] v, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      MODE_EVEN: r[0] = 1'b0;
      MODE_ODD:  r[0] = 1'b1;
      default:   r    = v;
    endcase
    return r;
  endfunction

  // Step size selected by the current mode, at the extended width.
  function automatic logic [WIDTH:0] step_f(input logic [1:0] m);
    logic [WIDTH:0] s;
    case (m)
      MODE_UNIT:  s = (WIDTH+1)'(1);
      MODE_PARAM: s = STEP_EXT;
      default:    s = (WIDTH+1)'(2);
    endcase
    return s;
  endfunction

  // Largest aligned value reachable in the current direction and mode.
  function automatic logic [WIDTH-1:0] limit_f(input logic up, input logic [1:0] m);
    logic [WIDTH-1:0] l;
    if (up) begin
      l = '1;
      if (m == MODE_EVEN) l[0] = 1'b0;
    end else begin
      l = '0;
      if (m == MODE_ODD) l[0] = 1'b1;
    end
    return l;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             at_limit_q, at_limit_d;

  logic [WIDTH-1:0] lim;
  logic [WIDTH:0]   raw;
  logic             ovf;

  // Next count: load beats count beats hold; at_limit is re-evaluated against the new q every edge.
  always_comb begin
    q_d        = q_q;
    tc_d       = 1'b0;
    lim        = limit_f(up_dn, mode);
    raw        = up_dn ? ({1'b0, q_q} + step_f(mode)) : ({1'b0, q_q} - step_f(mode));
    // Top bit of the extended sum is the carry going up or the borrow going down.
    ovf        = raw[WIDTH];
    if (load) begin
      q_d = align_f(load_val, mode);
    end else if (en) begin
      if (SATURATE) begin
        q_d  = ovf ? lim : align_f(raw[WIDTH-1:0], mode);
        // Pulse only on arrival at the limit; sitting there produces no further pulses.
        tc_d = (q_d == lim) && (q_q != lim);
      end else begin
        q_d  = align_f(raw[WIDTH-1:0], mode);
        tc_d = ovf;
      end
    end
    at_limit_d = (q_d == lim);
  end

  // State register; reset forces the start value and clears both flags without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q        <= START;
      tc_q       <= 1'b0;
      at_limit_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      tc_q       <= tc_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign q        = q_q;
  assign tc       = tc_q;
  assign at_limit = at_limit_q;

endmodule

// File: tb/tb_param_step_counter.sv
// Directed bench for param_step_counter: four instances cover 8-bit and 4-bit widths
// in wrap and saturate flavours, all sharing the same control inputs.
module tb_param_step_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up_dn, load;
  logic [1:0] mode;
  logic [7:0] load_val8;
  logic [3:0] load_val4;

  logic [7:0] q8, q8s;
  logic [3:0] q4, q4s;
  logic       tc8, tc8s, tc4, tc4s;
  logic       al8, al8s, al4, al4s;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [1:0] EVEN = 2'b00, ODD = 2'b01, UNIT = 2'b10, PARAM = 2'b11;

  always #5 clk = ~clk;

  param_step_counter #(.WIDTH(8), .STEP(3), .START(8'd0), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val8), .q(q8), .tc(tc8), .at_limit(al8));

  param_step_counter #(.WIDTH(8), .STEP(3), .START(8'd0), .SATURATE(1'b1)) u_w8s (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val8), .q(q8s), .tc(tc8s), .at_limit(al8s));

  param_step_counter #(.WIDTH(4), .STEP(3), .START(4'd0), .SATURATE(1'b0)) u_w4 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val4), .q(q4), .tc(tc4), .at_limit(al4));

  param_step_counter #(.WIDTH(4), .STEP(3), .START(4'd0), .SATURATE(1'b1)) u_w4s (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val4), .q(q4s), .tc(tc4s), .at_limit(al4s));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; mode = EVEN;
    load_val8 = '0; load_val4 = '0;

    // Reset state
    @(negedge clk);
    check("rst_q", q8, 0);
    check("rst_tc", tc8, 0);
    check("rst_al", al8, 0);
    check("rst_q4", q4, 0);

    // 1: EVEN up from reset, full 128-clock period with one tc at the wrap
    reset = 1'b0; en = 1'b1; mode = EVEN; up_dn = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      tick();
      check($sformatf("even_q%0d", i), q8, (2 * i) % 256);
      check($sformatf("even_tc%0d", i), tc8, (i == 128) ? 1 : 0);
      if (i == 127) check("even_al254", al8, 1);
    end

    // 2: ODD down from a loaded 5, wrapping through 255
    load = 1'b1; en = 1'b0; load_val8 = 8'd5; mode = ODD; up_dn = 1'b0;
    tick();
    check("odd_load_q", q8, 5);
    check("odd_load_tc", tc8, 0);
    load = 1'b0; en = 1'b1;
    tick(); check("odd_q3", q8, 3);   check("odd_tc3", tc8, 0);
    tick(); check("odd_q1", q8, 1);   check("odd_al1", al8, 1);
    tick(); check("odd_q255", q8, 255); check("odd_tc255", tc8, 1); check("odd_al255", al8, 0);
    tick(); check("odd_q253", q8, 253); check("odd_tc253", tc8, 0);

    // 4: load and enable together, load wins and is aligned
    load = 1'b1; en = 1'b1; load_val8 = 8'd7; mode = EVEN; up_dn = 1'b1;
    tick(); check("ld_pri_q", q8, 6); check("ld_pri_tc", tc8, 0);
    load = 1'b0;
    tick(); check("ld_next_q", q8, 8);

    // 5: async reset mid-cycle at q=40, pending load discarded
    load = 1'b1; en = 1'b0; load_val8 = 8'd40;
    tick(); check("pre_rst_q", q8, 40);
    load_val8 = 8'd100;
    #2 reset = 1'b1;
    #1;
    check("async_q", q8, 0);
    check("async_tc", tc8, 0);
    check("async_al", al8, 0);
    @(negedge clk);
    reset = 1'b0; load = 1'b0; en = 1'b1; mode = EVEN; up_dn = 1'b1;
    tick(); check("post_rst_q", q8, 2);

    // 3: saturating UNIT up from 253
    load = 1'b1; en = 1'b0; load_val8 = 8'd253; mode = UNIT; up_dn = 1'b1;
    tick(); check("sat_load_q", q8s, 253);
    load = 1'b0; en = 1'b1;
    tick(); check("sat_q1", q8s, 254); check("sat_tc1", tc8s, 0); check("sat_al1", al8s, 0);
    tick(); check("sat_q2", q8s, 255); check("sat_tc2", tc8s, 1); check("sat_al2", al8s, 1);
    tick(); check("sat_q3", q8s, 255); check("sat_tc3", tc8s, 0); check("sat_al3", al8s, 1);
    tick(); check("sat_q4", q8s, 255); check("sat_tc4", tc8s, 0); check("sat_al4", al8s, 1);

    // Mode change mid-count: q=5 in EVEN up steps to 7 then aligns to 6
    load = 1'b1; en = 1'b0; load_val8 = 8'd5; mode = UNIT;
    tick(); check("mchg_load", q8, 5);
    load = 1'b0; en = 1'b1; mode = EVEN;
    tick(); check("mchg_q", q8, 6);

    // Hold: en low keeps q and clears tc
    en = 1'b0;
    tick(); check("hold_q", q8, 6); check("hold_tc", tc8, 0);

    // 6: WIDTH=4 PARAM step 3 from 14, wrap and saturate
    load = 1'b1; load_val4 = 4'd14; mode = PARAM; up_dn = 1'b1;
    tick(); check("p4_load", q4, 14); check("p4s_load", q4s, 14);
    load = 1'b0; en = 1'b1;
    tick();
    check("p4_q1", q4, 1);   check("p4_tc1", tc4, 1);
    check("p4s_q1", q4s, 15); check("p4s_tc1", tc4s, 1); check("p4s_al1", al4s, 1);
    tick();
    check("p4_q2", q4, 4);   check("p4_tc2", tc4, 0); check("p4_al2", al4, 0);
    check("p4s_q2", q4s, 15); check("p4s_tc2", tc4s, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
